// File: rtl/ssd_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Anode vectors are active-low; the MSB of a NUM_DIGITS-wide vector is digit 0.
package ssd_pkg;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } ssd_state_e;

  // Widest anode vector the helper can build; NUM_DIGITS must not exceed it.
  localparam int unsigned MAX_DIGITS = 32;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // One-cold anode vector for slot idx: bit (num_digits-1-idx) low, all others high.
  function automatic logic [MAX_DIGITS-1:0] anode_onecold(input int unsigned idx,
                                                           input int unsigned num_digits);
    logic [MAX_DIGITS-1:0] v;
    v = ANODE_OFF;
    if (idx < num_digits) begin
      v = ANODE_OFF ^ (MAX_DIGITS'(1) << (num_digits - 1 - idx));
    end
    return v;
  endfunction

endpackage

// File: rtl/ssd_lz_mask.sv
// Combinational leading-zero mask; only built when SSD_LZ_SUPPRESS_EN is defined.
// mask[i] = 1 when digits 0..i are all zero and i is not the last digit.
`ifdef SSD_LZ_SUPPRESS_EN
module ssd_lz_mask #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIGIT_W    = 4
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic [NUM_DIGITS-1:0]         mask
);

  logic zero_run;

  // Running AND of "digit is zero" from the leftmost digit; last digit never masked.
  always_comb begin
    mask     = '0;
    zero_run = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS - 1; i++) begin
      zero_run = zero_run & (digits[i*DIGIT_W +: DIGIT_W] == '0);
      mask[i]  = zero_run;
    end
  end

endmodule
`endif

// File: rtl/ssd_scan_ctl.sv
// Self-timed multiplexed seven-segment scan controller with frame snapshot and dead time.
// Optional leading-zero suppression is enabled by defining SSD_LZ_SUPPRESS_EN.
module ssd_scan_ctl
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_W      = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  output logic [NUM_DIGITS-1:0]         ssd_ctl,
  output logic [DIGIT_W-1:0]            ssd_in,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_tick
);

  localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
  localparam int unsigned PRE_W    = $clog2(REFRESH_DIV);
  localparam int unsigned BUS_W    = NUM_DIGITS * DIGIT_W;
  localparam int unsigned SHOW_LEN = REFRESH_DIV - BLANK_CYCLES;

  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DARK     = NUM_DIGITS'(ANODE_OFF);

  ssd_state_e              state_q, state_d;
  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BUS_W-1:0]        snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [NUM_DIGITS-1:0]   ssd_ctl_q, ssd_ctl_d;
  logic [DIGIT_W-1:0]      ssd_in_q, ssd_in_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0]   cap_en_c;

`ifdef SSD_LZ_SUPPRESS_EN
  logic [NUM_DIGITS-1:0] lz_mask;

  ssd_lz_mask #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_lz_mask (
    .digits (digits),
    .mask   (lz_mask)
  );

  assign cap_en_c = digit_en & ~lz_mask;
`else
  assign cap_en_c = digit_en;
`endif

  // Next-state: prescaler, slot index, frame snapshot, and outputs for the upcoming cycle.
  always_comb begin
    state_d       = state_q;
    pre_d         = pre_q;
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_en_d     = snap_en_q;
    ssd_ctl_d     = ssd_ctl_q;
    ssd_in_d      = ssd_in_q;
    frame_tick_d  = 1'b0;

    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d         = '0;
        snap_digits_d = digits;
        snap_en_d     = cap_en_c;
        frame_tick_d  = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end

    // Dead time occupies the tail of each slot; absent entirely when BLANK_CYCLES is 0.
    state_d = (32'(pre_d) < SHOW_LEN) ? ST_SHOW : ST_BLANK;

    if (state_d == ST_SHOW) begin
      ssd_in_d  = snap_digits_d[idx_d*DIGIT_W +: DIGIT_W];
      ssd_ctl_d = snap_en_d[idx_d] ? NUM_DIGITS'(anode_onecold(32'(idx_d), NUM_DIGITS)) : DARK;
    end else begin
      ssd_ctl_d = DARK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      pre_q         <= PRE_LAST;
      idx_q         <= IDX_LAST;
      snap_digits_q <= '0;
      snap_en_q     <= '0;
      ssd_ctl_q     <= DARK;
      ssd_in_q      <= '0;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_en_q     <= snap_en_d;
      ssd_ctl_q     <= ssd_ctl_d;
      ssd_in_q      <= ssd_in_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign ssd_ctl    = ssd_ctl_q;
  assign ssd_in     = ssd_in_q;
  assign scan_idx   = idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Scoreboard bench for ssd_scan_ctl: hand-computed per-frame vectors expand into per-cycle
// expectations that a monitor pops and compares; a second instance runs with zero dead time.
module tb_ssd_scan_ctl;

  localparam int unsigned ND = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;

  typedef struct packed {
    logic [3:0] ctl;
    logic [3:0] din;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [3:0]  ssd_ctl;
  logic [3:0]  ssd_in;
  logic [1:0]  scan_idx;
  logic        frame_tick;

  logic        rst_n_b;
  logic [15:0] digits_b   = 16'h3210;
  logic [3:0]  digit_en_b = 4'hF;
  logic [3:0]  ssd_ctl_b;
  logic [3:0]  ssd_in_b;
  logic [1:0]  scan_idx_b;
  logic        frame_tick_b;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [3:0] cold_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  always #5 clk = ~clk;

  ssd_scan_ctl #(.NUM_DIGITS(ND), .DIGIT_W(DW), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .digits(digits), .digit_en(digit_en),
    .ssd_ctl(ssd_ctl), .ssd_in(ssd_in), .scan_idx(scan_idx), .frame_tick(frame_tick)
  );

  ssd_scan_ctl #(.NUM_DIGITS(ND), .DIGIT_W(DW), .REFRESH_DIV(RD), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .digits(digits_b), .digit_en(digit_en_b),
    .ssd_ctl(ssd_ctl_b), .ssd_in(ssd_in_b), .scan_idx(scan_idx_b), .frame_tick(frame_tick_b)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  // shown = digit codes expected on ssd_in (digit s at bits 4s+3:4s); lit = slots whose anode lights.
  task automatic push_frame(input logic [15:0] shown, input logic [3:0] lit);
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < int'(RD); p++) begin
        e.ctl  = (p < int'(RD - BC) && lit[s]) ? cold_tab[s] : 4'hF;
        e.din  = shown[s*4 +: 4];
        e.idx  = 2'(s);
        e.tick = (s == 0 && p == 0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_negedges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: one expectation per active edge while the scoreboard has entries.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ssd_ctl",    16'(ssd_ctl),    16'(e.ctl));
        chk("ssd_in",     16'(ssd_in),     16'(e.din));
        chk("scan_idx",   16'(scan_idx),   16'(e.idx));
        chk("frame_tick", 16'(frame_tick), 16'(e.tick));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // Zero-dead-time instance: anodes never all dark while scanning, async reset mid slot 2.
  initial begin : check_b
    @(posedge rst_n_b);
    for (int c = 0; c < 19; c++) begin
      @(posedge clk);
      #1;
      chk("b_never_dark", 16'(ssd_ctl_b == 4'hF), 16'(0));
    end
    chk("b_slot2_idx", 16'(scan_idx_b), 16'(2));
    chk("b_slot2_ctl", 16'(ssd_ctl_b),  16'(4'b1101));
    chk("b_slot2_in",  16'(ssd_in_b),   16'(2));
    #2 rst_n_b = 1'b0;
    #1;
    chk("b_async_ctl", 16'(ssd_ctl_b),  16'(4'hF));
    chk("b_async_idx", 16'(scan_idx_b), 16'(3));
    chk("b_async_in",  16'(ssd_in_b),   16'(0));
  end

  initial begin : stimulus
    logic [3:0] lit_5000;
    logic [3:0] lit_0000;
`ifdef SSD_LZ_SUPPRESS_EN
    lit_5000 = 4'b1000;
    lit_0000 = 4'b1000;
`else
    lit_5000 = 4'b1111;
    lit_0000 = 4'b1111;
`endif
    rst_n    = 1'b0;
    rst_n_b  = 1'b0;
    digits   = 16'h3210;
    digit_en = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl",    16'(ssd_ctl),    16'(4'hF));
    chk("rst_in",     16'(ssd_in),     16'(0));
    chk("rst_tick",   16'(frame_tick), 16'(0));
    chk("rst_idx",    16'(scan_idx),   16'(3));
    chk("rst_b_ctl",  16'(ssd_ctl_b),  16'(4'hF));

    @(negedge clk);
    push_frame(16'h3210, 4'hF);
    rst_n   = 1'b1;
    rst_n_b = 1'b1;
    run_negedges(32);

    // Mid-frame digit change stays invisible until the next frame.
    push_frame(16'h3210, 4'hF);
    run_negedges(10);
    digits = 16'h9999;
    run_negedges(22);

    push_frame(16'h9999, 4'hF);
    run_negedges(5);
    digits   = 16'h3210;
    digit_en = 4'b0101;
    run_negedges(27);

    push_frame(16'h3210, 4'b0101);
    run_negedges(31);
    // Change lands one cycle before the wrap edge and must be captured by it.
    digits   = 16'h5000;
    digit_en = 4'hF;
    run_negedges(1);

    push_frame(16'h5000, lit_5000);
    run_negedges(32);
    digits = 16'h0000;

    push_frame(16'h0000, lit_0000);
    run_negedges(32);

    // Asynchronous reset mid-operation, then scanning restarts from slot 0.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_ctl",  16'(ssd_ctl),    16'(4'hF));
    chk("async_in",   16'(ssd_in),     16'(0));
    chk("async_tick", 16'(frame_tick), 16'(0));
    chk("async_idx",  16'(scan_idx),   16'(3));
    @(negedge clk);
    digits   = 16'h3210;
    digit_en = 4'hF;
    push_frame(16'h3210, 4'hF);
    rst_n = 1'b1;
    run_negedges(32);

    chk("scoreboard_drained", 16'(exp_q.size()), 16'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
